pueo_surf_trig_collector: RTL and testbench

//  Parametrised successor to the fixed 32-SURF trigger intake in the master trigger path.

---
 rtl/pueo_trig_pkg.sv | 29 ++
 rtl/pueo_trig_fifo.sv | 72 +++++++
 rtl/pueo_surf_trig_collector.sv | 196 +++++++++++++++++++
 tb/tb_pueo_surf_trig_collector.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pueo_trig_pkg.sv
// Shared definitions for the SURF trigger collector: trigger-word field
// positions, output packing widths and the FIFO entry type.
package pueo_trig_pkg;

  // Width of one output beat / FIFO entry.
  localparam int OUT_W    = 64;
  // Width of the drop counter and of each per-SURF scaler.
  localparam int CNT_W    = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // The trigger flag is the MSB of each SURF word.
  function automatic int flag_bit(input int nbit);
    return nbit - 1;
  endfunction

  // Metadata is everything below the flag.
  function automatic int meta_width(input int nbit);
    return nbit - 1;
  endfunction

  // Used bits of an entry: {idx, meta, timestamp}.
  function automatic int packed_width(input int time_bits, input int nbit, input int idxw);
    return time_bits + (nbit - 1) + idxw;
  endfunction

  // One FIFO entry / one AXI beat: {pad, idx, meta, timestamp}, timestamp at LSB.
  typedef logic [OUT_W-1:0] trig_entry_t;

endpackage

// File: rtl/pueo_trig_fifo.sv
// Synchronous first-word-fall-through FIFO for packed trigger entries.
// rd_data shows the head entry whenever empty is low and reads as zero
// when the FIFO is empty. A read and a write in the same cycle are accepted
// even when full.
module pueo_trig_fifo
  import pueo_trig_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        wr_en,
  input  trig_entry_t wr_data,
  input  logic        rd_en,
  output trig_entry_t rd_data,
  output logic        full,
  output logic        empty
);

  localparam int AW = $clog2(DEPTH);

  generate
    if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_bad_depth
      $error("pueo_trig_fifo: DEPTH must be a power of 2 and >= 2");
    end
  endgenerate

  trig_entry_t    mem [DEPTH];
  logic [AW-1:0]  wr_ptr_q;
  logic [AW-1:0]  rd_ptr_q;
  logic [AW:0]    count_q;
  logic           do_wr;
  logic           do_rd;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = empty ? '0 : mem[rd_ptr_q];

  // Storage array write port.
  // NOTE: the storage array has no reset; rd_data is forced to zero while
  // empty, so stale contents are never visible and the array maps to RAM.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_q] <= wr_data;
  end

  // Pointer and occupancy bookkeeping.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/pueo_surf_trig_collector.sv
// SURF trigger collector: captures NSURF trigger words on each valid strobe,
// masks them, serialises the asserted SURFs round-robin with a shared
// timestamp into a FWFT FIFO, and presents them as an AXI4-Stream master.
// Optional feature macro: PUEO_TRIG_SCALER_EN adds per-SURF scaler counters
// on port scaler_o.
module pueo_surf_trig_collector
  import pueo_trig_pkg::*;
#(
  parameter int NSURF      = 32,
  parameter int NBIT       = 16,
  parameter int TIME_BITS  = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                    sysclk_i,
  input  logic                    rst_i,
  input  logic                    runrst_i,
  input  logic [NSURF-1:0]        trigmask_i,
  input  logic [15:0]             trig_offset_i,
  input  logic [15:0]             holdoff_i,
  input  logic [TIME_BITS-1:0]    cur_time_i,
  input  logic [NSURF*NBIT-1:0]   trigin_dat_i,
  input  logic                    trigin_dat_valid_i,
  output trig_entry_t             m_trig_tdata,
  output logic                    m_trig_tvalid,
  input  logic                    m_trig_tready,
  output logic [CNT_W-1:0]        drop_count_o,
  output logic                    busy_o
`ifdef PUEO_TRIG_SCALER_EN
  ,
  output logic [NSURF*CNT_W-1:0]  scaler_o
`endif
);

  localparam int IDXW   = $clog2(NSURF);
  localparam int META_W = meta_width(NBIT);
  localparam int FLAG_B = flag_bit(NBIT);
  localparam int PACK_W = packed_width(TIME_BITS, NBIT, IDXW);

  generate
    if (PACK_W > OUT_W) begin : g_bad_width
      $error("pueo_surf_trig_collector: TIME_BITS+NBIT-1+IDXW exceeds OUT_W");
    end
  endgenerate

  logic [NSURF-1:0]      pend_q;
  logic [NSURF-1:0]      pend_new;
  logic [META_W-1:0]     meta_q [NSURF];
  logic [TIME_BITS-1:0]  ts_q;
  logic [TIME_BITS-1:0]  ts_new;
  logic [15:0]           holdoff_q;
  logic [IDXW-1:0]       rr_q;
  logic [IDXW-1:0]       rr_next;
  logic [IDXW-1:0]       sel_idx;
  logic                  sel_found;
  logic                  capture;
  logic                  service;
  logic                  pop;
  logic                  fifo_ok;
  logic                  fifo_wr;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      drop_inc;
  logic [CNT_W:0]        drop_sum;
  trig_entry_t           wr_entry;

  // Index `base + k` wrapped into 0..NSURF-1 (k < NSURF).
  function automatic logic [IDXW-1:0] wrap_add(input logic [IDXW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NSURF) s = s - NSURF;
    return IDXW'(s);
  endfunction

  function automatic logic [CNT_W-1:0] popcount(input logic [NSURF-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < NSURF; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  // Masked flags of the incoming words and the offset-corrected capture time.
  // NOTE: every combinational output gets a default before any branch so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    pend_new = '0;
    for (int i = 0; i < NSURF; i++) begin
      pend_new[i] = trigin_dat_i[i*NBIT + FLAG_B] & ~trigmask_i[i];
    end
    ts_new = cur_time_i - TIME_BITS'(trig_offset_i);
  end

  // Round-robin pick: first pending SURF scanning upward from rr_q, wrapping.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = 0; k < NSURF; k++) begin
      if (!sel_found && pend_q[wrap_add(rr_q, k)]) begin
        sel_found = 1'b1;
        sel_idx   = wrap_add(rr_q, k);
      end
    end
  end

  // Per-cycle decisions: capture beats service, full FIFO turns service into a drop.
  always_comb begin
    capture  = trigin_dat_valid_i && (holdoff_q == '0);
    pop      = m_trig_tvalid && m_trig_tready;
    fifo_ok  = !fifo_full || pop;
    service  = !capture && sel_found;
    fifo_wr  = service && fifo_ok;
    rr_next  = (sel_idx == IDXW'(NSURF - 1)) ? '0 : sel_idx + 1'b1;
    drop_inc = '0;
    if (capture)               drop_inc = popcount(pend_q);
    else if (service && !fifo_ok) drop_inc = CNT_W'(1);
    drop_sum = {1'b0, drop_count_o} + {1'b0, drop_inc};
    wr_entry = OUT_W'({sel_idx, meta_q[sel_idx], ts_q});
  end

  // Control state: pending vector, round-robin pointer, holdoff, drop counter.
  always_ff @(posedge sysclk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_q       <= '0;
      rr_q         <= '0;
      holdoff_q    <= '0;
      drop_count_o <= '0;
    end else if (runrst_i) begin
      pend_q       <= '0;
      rr_q         <= '0;
      holdoff_q    <= '0;
      drop_count_o <= '0;
    end else begin
      if (capture) begin
        pend_q <= pend_new;
      end else if (service) begin
        pend_q[sel_idx] <= 1'b0;
        rr_q            <= rr_next;
      end
      if (holdoff_q != '0)
        holdoff_q <= holdoff_q - 1'b1;
      else if (capture && (pend_new != '0) && (holdoff_i != '0))
        holdoff_q <= holdoff_i;
      drop_count_o <= drop_sum[CNT_W] ? CNT_MAX : drop_sum[CNT_W-1:0];
    end
  end

  // Captured timestamp and metadata; only read while the matching pend bit is set.
  always_ff @(posedge sysclk_i) begin
    if (capture) begin
      ts_q <= ts_new;
      for (int i = 0; i < NSURF; i++) meta_q[i] <= trigin_dat_i[i*NBIT +: META_W];
    end
  end

  assign busy_o        = (pend_q != '0) || (holdoff_q != '0);
  assign m_trig_tvalid = !fifo_empty;

  pueo_trig_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (sysclk_i),
    .rst     (rst_i),
    .clr     (runrst_i),
    .wr_en   (fifo_wr),
    .wr_data (wr_entry),
    .rd_en   (m_trig_tready),
    .rd_data (m_trig_tdata),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

`ifdef PUEO_TRIG_SCALER_EN
  logic [CNT_W-1:0] scaler_q [NSURF];

  // Per-SURF saturating count of unmasked flags at accepted captures.
  always_ff @(posedge sysclk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NSURF; i++) scaler_q[i] <= '0;
    end else if (runrst_i) begin
      for (int i = 0; i < NSURF; i++) scaler_q[i] <= '0;
    end else if (capture) begin
      for (int i = 0; i < NSURF; i++) begin
        if (pend_new[i] && scaler_q[i] != CNT_MAX) scaler_q[i] <= scaler_q[i] + 1'b1;
      end
    end
  end

  // Flatten the scaler array onto the output port.
  always_comb begin
    scaler_o = '0;
    for (int i = 0; i < NSURF; i++) scaler_o[i*CNT_W +: CNT_W] = scaler_q[i];
  end
`else
  // Scalers not built in this configuration.
`endif

endmodule

// File: tb/tb_pueo_surf_trig_collector.sv
// Scoreboard bench for pueo_surf_trig_collector. A reference model steps on
// each rising clock and pushes expected beats; a monitor on the falling
// clock compares DUT beats, tvalid, busy and drop count against the model.
module tb_pueo_surf_trig_collector;

  localparam int NSURF      = 32;
  localparam int NBIT       = 16;
  localparam int TIME_BITS  = 32;
  localparam int FIFO_DEPTH = 16;
  localparam int MW         = NBIT - 1;
  localparam int IDX_SH     = TIME_BITS + NBIT - 1;

  logic                   sysclk_i = 1'b0;
  logic                   rst_i = 1'b1;
  logic                   runrst_i = 1'b0;
  logic [NSURF-1:0]       trigmask_i = '0;
  logic [15:0]            trig_offset_i = '0;
  logic [15:0]            holdoff_i = '0;
  logic [TIME_BITS-1:0]   cur_time_i = '0;
  logic [NSURF*NBIT-1:0]  trigin_dat_i = '0;
  logic                   trigin_dat_valid_i = 1'b0;
  logic [63:0]            m_trig_tdata;
  logic                   m_trig_tvalid;
  logic                   m_trig_tready = 1'b0;
  logic [15:0]            drop_count_o;
  logic                   busy_o;
`ifdef PUEO_TRIG_SCALER_EN
  logic [NSURF*16-1:0]    scaler_o;
`endif

  always #5 sysclk_i = ~sysclk_i;

  pueo_surf_trig_collector #(
    .NSURF(NSURF), .NBIT(NBIT), .TIME_BITS(TIME_BITS), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .sysclk_i           (sysclk_i),
    .rst_i              (rst_i),
    .runrst_i           (runrst_i),
    .trigmask_i         (trigmask_i),
    .trig_offset_i      (trig_offset_i),
    .holdoff_i          (holdoff_i),
    .cur_time_i         (cur_time_i),
    .trigin_dat_i       (trigin_dat_i),
    .trigin_dat_valid_i (trigin_dat_valid_i),
    .m_trig_tdata       (m_trig_tdata),
    .m_trig_tvalid      (m_trig_tvalid),
    .m_trig_tready      (m_trig_tready),
    .drop_count_o       (drop_count_o),
    .busy_o             (busy_o)
`ifdef PUEO_TRIG_SCALER_EN
    , .scaler_o         (scaler_o)
`endif
  );

  int          tests = 0;
  int          fails = 0;
  logic [63:0] exp_q[$];
  logic [63:0] beat_log[$];
  bit          rand_ready = 0;

  // Reference model state: pending SURFs kept as an ordered service list.
  int                   m_order[$];
  int                   m_rr = 0;
  int                   m_hold = 0;
  int                   m_cnt = 0;
  int                   m_drop = 0;
  logic [TIME_BITS-1:0] m_ts = '0;
  logic [MW-1:0]        m_meta [NSURF];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  // One clock of the specification's behaviour, evaluated on pre-edge inputs.
  task automatic model_step();
    bit cap, popd, full;
    int idx;
    logic [63:0] e;
    if (rst_i || runrst_i) begin
      m_order.delete(); m_rr = 0; m_hold = 0; m_cnt = 0; m_drop = 0; exp_q.delete();
      return;
    end
    cap  = trigin_dat_valid_i && (m_hold == 0);
    popd = (m_cnt > 0) && m_trig_tready;
    full = (m_cnt == FIFO_DEPTH);
    if (m_hold > 0) m_hold--;
    if (cap) begin
      m_drop = sat16(m_drop + m_order.size());
      m_order.delete();
      for (int k = 0; k < NSURF; k++) begin
        idx = (m_rr + k) % NSURF;
        if (trigin_dat_i[idx*NBIT + NBIT-1] && !trigmask_i[idx]) m_order.push_back(idx);
      end
      m_ts = cur_time_i - TIME_BITS'(trig_offset_i);
      for (int i = 0; i < NSURF; i++) m_meta[i] = trigin_dat_i[i*NBIT +: MW];
      if (m_order.size() > 0 && holdoff_i > 0) m_hold = holdoff_i;
    end else if (m_order.size() > 0) begin
      idx  = m_order.pop_front();
      m_rr = (idx + 1) % NSURF;
      if (!full || popd) begin
        e = (64'(idx) << IDX_SH) | (64'(m_meta[idx]) << TIME_BITS) | 64'(m_ts);
        exp_q.push_back(e);
        m_cnt++;
      end else begin
        m_drop = sat16(m_drop + 1);
      end
    end
    if (popd) m_cnt--;
  endtask

  task automatic monitor_step();
    logic [63:0] e;
    if (rst_i || runrst_i) return;
    check("tvalid", 64'(m_trig_tvalid), 64'(m_cnt != 0));
    check("drop_count", 64'(drop_count_o), 64'(m_drop));
    check("busy", 64'(busy_o), 64'(m_order.size() != 0 || m_hold != 0));
    if (m_trig_tvalid && m_trig_tready) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL beat_unexpected: got %0h expected no beat at %0t", m_trig_tdata, $time);
      end else begin
        e = exp_q.pop_front();
        check("tdata", m_trig_tdata, e);
      end
      beat_log.push_back(m_trig_tdata);
    end
  endtask

  initial forever begin @(posedge sysclk_i); model_step();   end
  initial forever begin @(negedge sysclk_i); monitor_step(); end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge sysclk_i); #1;
      cur_time_i = cur_time_i + 1'b1;
      if (rand_ready) m_trig_tready = ($urandom_range(0, 3) != 0);
    end
  endtask

  function automatic logic [NSURF*NBIT-1:0] make_dat(input logic [NSURF-1:0] flags);
    logic [NSURF*NBIT-1:0] d;
    logic [MW-1:0] m;
    for (int i = 0; i < NSURF; i++) begin
      m = MW'($urandom);
      d[i*NBIT +: NBIT] = {flags[i], m};
    end
    return d;
  endfunction

  task automatic pulse(input logic [NSURF*NBIT-1:0] d);
    trigin_dat_i = d;
    trigin_dat_valid_i = 1'b1;
    step();
    trigin_dat_valid_i = 1'b0;
  endtask

  task automatic send(input logic [NSURF*NBIT-1:0] d);
    pulse(d);
    step(3);
  endtask

  task automatic drain();
    bit done;
    done = 0;
    rand_ready = 0;
    m_trig_tready = 1'b1;
    for (int c = 0; c < 400 && !done; c++) begin
      if (exp_q.size() == 0 && m_order.size() == 0 && m_cnt == 0 && m_hold == 0) done = 1;
      else step();
    end
    if (!done) begin
      tests++; fails++;
      $display("FAIL drain_timeout: got pending=%0d expected 0", exp_q.size());
    end
  endtask

  function automatic int beat_idx(input logic [63:0] b);
    logic [63:0] s;
    s = b >> IDX_SH;
    return int'(s[4:0]);
  endfunction

  initial begin
    logic [NSURF*NBIT-1:0] d;
    logic [NSURF-1:0] flags;
    int exp_idx[4];
    logic [31:0] t0, t1;

    // Reset state
    step(2);
    rst_i = 1'b0;
    step();
    check("reset_tvalid", 64'(m_trig_tvalid), 64'd0);
    check("reset_tdata", m_trig_tdata, 64'd0);
    check("reset_drop", 64'(drop_count_o), 64'd0);
    check("reset_busy", 64'(busy_o), 64'd0);

    // Single unmasked SURF0: idx 0, meta 0x10, ts 1000-100
    m_trig_tready = 1'b1;
    trigmask_i = ~32'h1;
    trig_offset_i = 16'd100;
    d = make_dat('1);
    d[15:0] = 16'h8010;
    cur_time_i = 32'd1000;
    beat_log.delete();
    send(d);
    drain();
    check("t2_beats", 64'(beat_log.size()), 64'd1);
    if (beat_log.size() > 0) check("t2_entry", beat_log[0], 64'h0000_0010_0000_0384);

    // Flag only on a masked SURF: nothing comes out, nothing is dropped
    beat_log.delete();
    send(make_dat(32'h2));
    step(4);
    check("t3_beats", 64'(beat_log.size()), 64'd0);
    check("t3_drop", 64'(drop_count_o), 64'd0);

    // Round-robin ordering across captures
    trigmask_i = '0;
    beat_log.delete();
    send(make_dat((32'h1 << 3) | (32'h1 << 7)));
    drain();
    send(make_dat((32'h1 << 3) | (32'h1 << 9)));
    drain();
    exp_idx = '{3, 7, 9, 3};
    check("t4_beats", 64'(beat_log.size()), 64'd4);
    for (int k = 0; k < 4 && k < beat_log.size(); k++)
      check("t4_idx", 64'(beat_idx(beat_log[k])), 64'(exp_idx[k]));

    // FIFO overflow with a stalled consumer
    cur_time_i = 32'd5000;
    m_trig_tready = 1'b0;
    flags = 32'h1 << 5;
    repeat (20) send(make_dat(flags));
    check("t5_drop", 64'(drop_count_o), 64'd4);
    check("t5_held_valid", 64'(m_trig_tvalid), 64'd1);
    beat_log.delete();
    drain();
    check("t5_beats", 64'(beat_log.size()), 64'd16);
    for (int k = 0; k + 1 < beat_log.size(); k++) begin
      t0 = beat_log[k][31:0];
      t1 = beat_log[k+1][31:0];
      check("t5_order", 64'(t1 > t0), 64'd1);
    end

    // Run reset clears the drop counter; then holdoff suppresses one strobe
    runrst_i = 1'b1;
    step();
    runrst_i = 1'b0;
    check("runrst_drop", 64'(drop_count_o), 64'd0);
    holdoff_i = 16'd10;
    beat_log.delete();
    flags = 32'h1 << 2;
    pulse(make_dat(flags));
    step(3);
    pulse(make_dat(flags));
    step(7);
    pulse(make_dat(flags));
    drain();
    check("t6_beats", 64'(beat_log.size()), 64'd2);
    check("t6_drop", 64'(drop_count_o), 64'd0);
    holdoff_i = '0;

    // Randomised traffic, including time wrap and run resets
    cur_time_i = 32'hFFFF_FF80;
    rand_ready = 1;
    for (int it = 0; it < 300; it++) begin
      trigmask_i = ($urandom_range(0, 1) != 0) ? '0 : NSURF'($urandom);
      flags = NSURF'($urandom & $urandom & $urandom);
      holdoff_i = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(1, 12)) : 16'd0;
      trig_offset_i = 16'($urandom);
      pulse(make_dat(flags));
      step($urandom_range(0, 5));
      if (it % 100 == 99) begin
        runrst_i = 1'b1;
        step();
        runrst_i = 1'b0;
      end
    end
    drain();
    holdoff_i = '0;

    // Asynchronous reset in the middle of a stalled burst
    m_trig_tready = 1'b0;
    trigmask_i = '0;
    for (int it = 0; it < 6; it++) begin
      pulse(make_dat(NSURF'($urandom | 32'h1)));
      step($urandom_range(0, 2));
    end
    #2;
    rst_i = 1'b1;
    #1;
    check("async_rst_tvalid", 64'(m_trig_tvalid), 64'd0);
    check("async_rst_drop", 64'(drop_count_o), 64'd0);
    check("async_rst_busy", 64'(busy_o), 64'd0);
    step();
    rst_i = 1'b0;

    // Recovery after reset
    beat_log.delete();
    send(make_dat(32'h1 << 11));
    drain();
    check("recover_beats", 64'(beat_log.size()), 64'd1);
    if (beat_log.size() > 0) check("recover_idx", 64'(beat_idx(beat_log[0])), 64'd11);

    step(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
